// File: rtl/gate_truth_checker_if.sv
// Bus between the truth checker and the side that owns the gate under test:
// run control, stimulus/response and the result registers.
interface gate_truth_checker_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic              start;
  logic [N_IN-1:0]   dut_in;
  logic              dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic              first_err_valid;
  logic [N_IN-1:0]   first_err_vec;

  // Checker side: drives the stimulus and results, observes start and y.
  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count, first_err_valid, first_err_vec
  );

  // Gate/host side: requests runs, returns y, reads the results.
  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Exhaustive in-hardware checker for a small combinational gate. Every input
// vector is applied for HOLD_CYCLES cycles, the gate output is sampled in a
// single CHECK cycle and compared against the TRUTH table. Mismatches are
// counted (saturating) and the first failing vector is recorded.
module gate_truth_checker #(
  parameter int                        N_IN        = 2,
  parameter logic [(1 << N_IN) - 1:0]  TRUTH       = 4'b1110,
  parameter int                        HOLD_CYCLES = 10,
  parameter int                        ERR_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_truth_checker_if.master bus
);

  localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_VEC  = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [N_IN-1:0]   vec_idx, vec_idx_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic [ERR_W-1:0]  err_cnt, err_cnt_next;
  logic              ferr_vld, ferr_vld_next;
  logic [N_IN-1:0]   ferr_vec, ferr_vec_next;
  logic              busy_r, busy_next;
  logic              done_r, done_next;
  logic              pass_r, pass_next;
  logic              mismatch;
  logic [ERR_W-1:0]  err_after;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + ERR_W'(1);
  endfunction

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-value logic for the run sequencer and result registers.
  always_comb begin
    state_next     = state;
    vec_idx_next   = vec_idx;
    hold_cnt_next  = hold_cnt;
    err_cnt_next   = err_cnt;
    ferr_vld_next  = ferr_vld;
    ferr_vec_next  = ferr_vec;
    busy_next      = busy_r;
    done_next      = done_r;
    pass_next      = pass_r;
    mismatch       = (bus.dut_out != TRUTH[vec_idx]);
    err_after      = mismatch ? sat_inc(err_cnt) : err_cnt;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next    = APPLY;
          vec_idx_next  = '0;
          hold_cnt_next = '0;
          err_cnt_next  = '0;
          ferr_vld_next = 1'b0;
          ferr_vec_next = '0;
          busy_next     = 1'b1;
          done_next     = 1'b0;
          pass_next     = 1'b0;
        end
      end
      APPLY: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next    = CHECK;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt + HOLD_W'(1);
        end
      end
      CHECK: begin
        err_cnt_next = err_after;
        if (mismatch && !ferr_vld) begin
          ferr_vld_next = 1'b1;
          ferr_vec_next = vec_idx;
        end
        if (vec_idx == LAST_VEC) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          pass_next  = (err_after == '0);
        end else begin
          state_next   = APPLY;
          vec_idx_next = vec_idx + N_IN'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stimulus index, hold counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx  <= '0;
      hold_cnt <= '0;
      err_cnt  <= '0;
      ferr_vld <= 1'b0;
      ferr_vec <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      vec_idx  <= vec_idx_next;
      hold_cnt <= hold_cnt_next;
      err_cnt  <= err_cnt_next;
      ferr_vld <= ferr_vld_next;
      ferr_vec <= ferr_vec_next;
      busy_r   <= busy_next;
      done_r   <= done_next;
      pass_r   <= pass_next;
    end
  end

  assign bus.dut_in          = vec_idx;
  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.pass            = pass_r;
  assign bus.err_count       = err_cnt;
  assign bus.first_err_valid = ferr_vld;
  assign bus.first_err_vec   = ferr_vec;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three checker instances (default OR table,
// AND table, and a fast HOLD_CYCLES=1 / ERR_W=1 build) each watching a
// behavioural gate whose function is selectable per run.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  gate_truth_checker_if #(.N_IN(2), .ERR_W(8)) if_a ();
  gate_truth_checker_if #(.N_IN(2), .ERR_W(8)) if_b ();
  gate_truth_checker_if #(.N_IN(2), .ERR_W(1)) if_c ();

  gate_truth_checker #(.N_IN(2), .TRUTH(4'b1110), .HOLD_CYCLES(10), .ERR_W(8))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  gate_truth_checker #(.N_IN(2), .TRUTH(4'b1000), .HOLD_CYCLES(10), .ERR_W(8))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  gate_truth_checker #(.N_IN(2), .TRUTH(4'b1110), .HOLD_CYCLES(1), .ERR_W(1))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  // Gate selection: 0 OR, 1 stuck-at-0, 2 AND, 3 NOR (inverted OR).
  int         g_sel [3] = '{0, 0, 3};
  int         hold_c[3] = '{10, 10, 1};
  logic [3:0] truth_c[3] = '{4'b1110, 4'b1000, 4'b1110};
  int         emax_c[3] = '{255, 255, 1};

  // Model state: edges since the start edge, running, finished, gate used.
  int m_cyc[3];
  bit m_run[3];
  bit m_fin[3];
  int m_sel[3];

  function automatic logic gate(input int sel, input logic [1:0] v);
    case (sel)
      0:       return v[0] | v[1];
      1:       return 1'b0;
      2:       return v[0] & v[1];
      default: return ~(v[0] | v[1]);
    endcase
  endfunction

  always_comb if_a.dut_out = gate(g_sel[0], if_a.dut_in);
  always_comb if_b.dut_out = gate(g_sel[1], if_b.dut_in);
  always_comb if_c.dut_out = gate(g_sel[2], if_c.dut_in);

  function automatic logic get_start(input int i);
    case (i)
      0:       return if_a.start;
      1:       return if_b.start;
      default: return if_c.start;
    endcase
  endfunction

  function automatic logic get_done(input int i);
    case (i)
      0:       return if_a.done;
      1:       return if_b.done;
      default: return if_c.done;
    endcase
  endfunction

  task automatic set_start(input int i, input logic v);
    case (i)
      0:       if_a.start = v;
      1:       if_b.start = v;
      default: if_c.start = v;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model sequencing: a run lasts 4*(hold+1) edges from the edge sampling start.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_cyc[i] = 0;
        m_run[i] = 1'b0;
        m_fin[i] = 1'b0;
        m_sel[i] = 0;
      end else if (get_start(i) && !m_run[i]) begin
        m_run[i] = 1'b1;
        m_cyc[i] = 0;
        m_sel[i] = g_sel[i];
      end else if (m_run[i]) begin
        m_cyc[i]++;
        if (m_cyc[i] == 4 * (hold_c[i] + 1)) begin
          m_run[i] = 1'b0;
          m_fin[i] = 1'b1;
        end
      end
    end
  end

  // Expected outputs: vectors whose check has completed are scored against
  // the truth table; the current vector is the elapsed time over the slot.
  task automatic model_exp(input int i, output int e_in, output int e_busy,
                           output int e_done, output int e_pass, output int e_err,
                           output int e_fvld, output int e_fvec);
    int per;
    int checked;
    int errs;
    int first;
    logic [1:0] v2;
    per   = hold_c[i] + 1;
    errs  = 0;
    first = -1;
    if (m_run[i])      checked = m_cyc[i] / per;
    else if (m_fin[i]) checked = 4;
    else               checked = 0;
    for (int v = 0; v < checked; v++) begin
      v2 = 2'(v);
      if (gate(m_sel[i], v2) != truth_c[i][v]) begin
        errs++;
        if (first < 0) first = v;
      end
    end
    e_err  = (errs > emax_c[i]) ? emax_c[i] : errs;
    e_fvld = (first >= 0) ? 1 : 0;
    e_fvec = (first >= 0) ? first : 0;
    e_in   = m_run[i] ? (m_cyc[i] / per) : (m_fin[i] ? 3 : 0);
    e_busy = m_run[i] ? 1 : 0;
    e_done = (m_fin[i] && !m_run[i]) ? 1 : 0;
    e_pass = (e_done == 1 && errs == 0) ? 1 : 0;
  endtask

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    int e_in, e_busy, e_done, e_pass, e_err, e_fvld, e_fvec;
    if (!rst) begin
      model_exp(0, e_in, e_busy, e_done, e_pass, e_err, e_fvld, e_fvec);
      chk("a.dut_in", int'(if_a.dut_in), e_in);
      chk("a.busy", int'(if_a.busy), e_busy);
      chk("a.done", int'(if_a.done), e_done);
      chk("a.pass", int'(if_a.pass), e_pass);
      chk("a.err_count", int'(if_a.err_count), e_err);
      chk("a.first_err_valid", int'(if_a.first_err_valid), e_fvld);
      if (e_fvld == 1) chk("a.first_err_vec", int'(if_a.first_err_vec), e_fvec);
      model_exp(1, e_in, e_busy, e_done, e_pass, e_err, e_fvld, e_fvec);
      chk("b.dut_in", int'(if_b.dut_in), e_in);
      chk("b.busy", int'(if_b.busy), e_busy);
      chk("b.done", int'(if_b.done), e_done);
      chk("b.pass", int'(if_b.pass), e_pass);
      chk("b.err_count", int'(if_b.err_count), e_err);
      chk("b.first_err_valid", int'(if_b.first_err_valid), e_fvld);
      model_exp(2, e_in, e_busy, e_done, e_pass, e_err, e_fvld, e_fvec);
      chk("c.dut_in", int'(if_c.dut_in), e_in);
      chk("c.busy", int'(if_c.busy), e_busy);
      chk("c.done", int'(if_c.done), e_done);
      chk("c.pass", int'(if_c.pass), e_pass);
      chk("c.err_count", int'(if_c.err_count), e_err);
      chk("c.first_err_valid", int'(if_c.first_err_valid), e_fvld);
      if (e_fvld == 1) chk("c.first_err_vec", int'(if_c.first_err_vec), e_fvec);
    end
  end

  // Pulse start on instance i and count edges until done; optionally pulse
  // start again repulse_at edges into the run. done_after reports done
  // right after the start edge.
  task automatic run(input int i, input int repulse_at, output int cycles,
                     output int done_after);
    @(posedge clk); #1;
    set_start(i, 1'b1);
    @(posedge clk); #1;
    set_start(i, 1'b0);
    done_after = int'(get_done(i));
    cycles = 0;
    while (!get_done(i) && cycles < 500) begin
      set_start(i, (cycles == repulse_at) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      cycles++;
    end
    set_start(i, 1'b0);
  endtask

  initial begin
    int cyc;
    int dn;
    int guard;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", int'(if_a.busy), 0);
    chk("rst.done", int'(if_a.done), 0);
    chk("rst.pass", int'(if_a.pass), 0);
    chk("rst.dut_in", int'(if_a.dut_in), 0);
    chk("rst.err_count", int'(if_a.err_count), 0);
    rst = 1'b0;

    // 1: correct OR gate
    g_sel[0] = 0;
    run(0, -1, cyc, dn);
    chk("t1.cycles", cyc, 44);
    chk("t1.pass", int'(if_a.pass), 1);
    chk("t1.err_count", int'(if_a.err_count), 0);
    chk("t1.first_err_valid", int'(if_a.first_err_valid), 0);

    // 2: output stuck at 0
    g_sel[0] = 1;
    run(0, -1, cyc, dn);
    chk("t2.cycles", cyc, 44);
    chk("t2.pass", int'(if_a.pass), 0);
    chk("t2.err_count", int'(if_a.err_count), 3);
    chk("t2.first_err_valid", int'(if_a.first_err_valid), 1);
    chk("t2.first_err_vec", int'(if_a.first_err_vec), 1);

    // 3: AND gate against OR table, then against AND table
    g_sel[0] = 2;
    run(0, -1, cyc, dn);
    chk("t3.err_count", int'(if_a.err_count), 2);
    chk("t3.first_err_vec", int'(if_a.first_err_vec), 1);
    g_sel[1] = 2;
    run(1, -1, cyc, dn);
    chk("t3b.cycles", cyc, 44);
    chk("t3b.pass", int'(if_b.pass), 1);

    // 4: start during a run is ignored; start in DONE restarts
    g_sel[0] = 1;
    run(0, 20, cyc, dn);
    chk("t4.cycles", cyc, 44);
    chk("t4.err_count", int'(if_a.err_count), 3);
    g_sel[0] = 0;
    run(0, -1, cyc, dn);
    chk("t4.done_after_start", dn, 0);
    chk("t4.cycles2", cyc, 44);
    chk("t4.pass2", int'(if_a.pass), 1);

    // 5: asynchronous reset mid-run while vector 2'b10 is applied
    g_sel[0] = 1;
    @(posedge clk); #1;
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    guard = 0;
    while (if_a.dut_in != 2'b10 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("t5.reach_vec2", int'(if_a.dut_in), 2);
    #1;
    rst = 1'b1;
    #1;
    chk("t5.async_busy", int'(if_a.busy), 0);
    chk("t5.async_dut_in", int'(if_a.dut_in), 0);
    chk("t5.async_err_count", int'(if_a.err_count), 0);
    chk("t5.async_first_err_valid", int'(if_a.first_err_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    g_sel[0] = 0;
    run(0, -1, cyc, dn);
    chk("t5.cycles", cyc, 44);
    chk("t5.pass", int'(if_a.pass), 1);

    // 6: short hold, 1-bit counter, inverted-output gate
    g_sel[2] = 3;
    run(2, -1, cyc, dn);
    chk("t6.cycles", cyc, 8);
    chk("t6.err_count", int'(if_c.err_count), 1);
    chk("t6.first_err_valid", int'(if_c.first_err_valid), 1);
    chk("t6.first_err_vec", int'(if_c.first_err_vec), 0);
    chk("t6.pass", int'(if_c.pass), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Synthesizable self-checking harness for small combinational gates such as or_gate and and_gate. It drives every input combination onto the DUT and holds each for a fixed settle time. It then samples the DUT output, compares it against a parameterised truth table, and reports the error count and the first failing vector. It sits beside a gate instance on the FPGA, so the same exhaustive check the simulation benches perform also runs in hardware.

Parameters:
N_IN, 2, number of DUT inputs; 2^N_IN vectors are applied (1..4 supported).
TRUTH, 4'b1110, expected output per vector; bit i = expected y for input vector i. Default is the OR function. Width is 2^N_IN.
HOLD_CYCLES, 10, clock cycles each vector is held before sampling (>=1).
ERR_W, 8, width of the error counter.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a run; sampled in IDLE or DONE only.
dut_in  out  N_IN  stimulus vector to DUT; dut_in[0] = a, dut_in[1] = b.
dut_out  in  1  DUT output y.
busy  out  1  high while vectors are being applied and checked.
done  out  1  level; high from run completion until the next start or rst.
pass  out  1  valid when done=1; 1 iff err_count == 0.
err_count  out  ERR_W  number of mismatching vectors; saturates at all-ones.
first_err_valid  out  1  at least one mismatch has occurred this run.
first_err_vec  out  N_IN  vector index of the first mismatch.

Behaviour:
- Reset (async, immediate on rst=1):
  - state = IDLE.
  - dut_in = 0, busy = 0, done = 0, pass = 0.
  - err_count = 0, first_err_valid = 0, first_err_vec = 0.
  - Internal hold counter = 0, vector index = 0.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE / DONE:
  - start=1 at an edge → APPLY.
  - At that same edge: vector index = 0, hold counter = 0, err_count = 0, first_err_valid = 0, first_err_vec = 0, done = 0.
- APPLY:
  - busy = 1; dut_in = vector index, held stable.
  - Hold counter increments each cycle.
  - When counter == HOLD_CYCLES-1 → CHECK, counter cleared.
- CHECK (one cycle, dut_in unchanged):
  - At the exiting edge, compare dut_out with TRUTH[vector index].
  - On mismatch: err_count += 1 (saturating).
  - On the first mismatch of the run: first_err_vec = index, first_err_valid = 1.
  - If index == 2^N_IN-1 → DONE. Otherwise index += 1 → APPLY.
- DONE: busy = 0, done = 1, pass = (err_count == 0); dut_in holds the last vector.
- Timing:
  - Each vector occupies HOLD_CYCLES+1 cycles.
  - done rises exactly 2^N_IN*(HOLD_CYCLES+1) rising edges after the edge that sampled start.
  - Defaults give 44 cycles.
- start while busy is ignored; the run continues unchanged.
- start held high continuously: a new run starts on the first edge in DONE.
- dut_out is sampled only in CHECK; glitches during APPLY have no effect.
- rst mid-run aborts immediately to the reset values. No partial results are retained.
- All outputs are registered; no combinational path from dut_out to any output.

Test Plan:
1. Correct or_gate, default params, start pulse → dut_in steps 00,01,10,11, each held 11 cycles; done=1 at cycle 44; pass=1, err_count=0, first_err_valid=0.
2. DUT y stuck at 0 → done at 44; pass=0, err_count=3, first_err_valid=1, first_err_vec=2'b01.
3. and_gate as DUT with TRUTH=4'b1110 → err_count=2, first_err_vec=2'b01. Re-run with TRUTH=4'b1000 → pass=1.
4. start pulsed again at cycle 20 of a run → ignored; done still at cycle 44 with the same results. Then start in DONE → done drops next cycle, err_count clears, new run completes at +44.
5. rst asserted while dut_in=2'b10 → outputs return to reset values asynchronously, before the next edge. After release, start → full run passes.
6. HOLD_CYCLES=1, ERR_W=1, inverted-output DUT → done after 8 cycles; err_count saturates at 1; first_err_vec=2'b00.
